grf_wb: RTL and testbench

- Write-back stage datapath plus general register file for the 5-stage MIPS pipeline.
- Consumes the WB-stage control triple (we, wd_type, waddr) from the WB control decoder, together with the WB-stage ALU result, memory read data and PC.
- Selects the write data and commits it to a 32x32 register file.
- Serves the ID stage's two combinational read ports, with internal write-to-read bypass.

---
 rtl/grf_wb.sv | 97 +++++++++
 tb/tb_grf_wb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb.sv
// grf_wb: write-back data select plus the 32x32 general register file.
// The WB stage picks its write data (ALU, memory, link address) and commits it
// to the register file. The two ID-stage read ports are combinational and
// bypass a write that commits in the same cycle, so ID never stalls on WB.
module grf_wb #(
  parameter int unsigned  DW          = 32,
  parameter logic [DW-1:0] GP_INIT    = DW'(32'h0000_1800),
  parameter logic [DW-1:0] SP_INIT    = DW'(32'h0000_2ffc),
  parameter int unsigned  PC_LINK_OFF = 8,
  localparam int unsigned AW          = 5,
  localparam int unsigned NREG        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    wd_type,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] alu_res,
  input  logic [DW-1:0] mem_data,
  input  logic [31:0]   pc,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] wb_data,
  output logic          wb_commit
);

  localparam int unsigned GP_IDX = 28;
  localparam int unsigned SP_IDX = 29;

  logic [DW-1:0] regs_q [NREG];
  logic          wd_ok;

  // Write-data select; reserved or unknown codes give zero and block the write
  always_comb begin
    wb_data = '0;
    wd_ok   = 1'b0;
    case (wd_type)
      2'd0: begin
        wb_data = alu_res;
        wd_ok   = 1'b1;
      end
      2'd1: begin
        wb_data = mem_data;
        wd_ok   = 1'b1;
      end
      2'd2: begin
        wb_data = DW'(pc + 32'(PC_LINK_OFF));
        wd_ok   = 1'b1;
      end
      default: begin
        wb_data = '0;
        wd_ok   = 1'b0;
      end
    endcase
  end

  // Commit qualifier: gated by reset so bypass and writes are off while in reset
  always_comb begin
    wb_commit = reset & we & (waddr != '0) & wd_ok;
  end

  // Register array: async reset to the boot image, one write per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      regs_q[GP_IDX] <= GP_INIT;
      regs_q[SP_IDX] <= SP_INIT;
    end else if (wb_commit) begin
      regs_q[waddr] <= wb_data;
    end
  end

  // Read port 1: $0 hardwired, same-cycle bypass, else array
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wb_commit && (waddr == raddr1)) begin
      rdata1 = wb_data;
    end
  end

  // Read port 2: identical to port 1
  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wb_commit && (waddr == raddr2)) begin
      rdata2 = wb_data;
    end
  end

endmodule

// File: tb/tb_grf_wb.sv
// Bench for grf_wb: directed vectors push expected output values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_grf_wb;

  localparam int unsigned SEL_RD1 = 0;
  localparam int unsigned SEL_RD2 = 1;
  localparam int unsigned SEL_WBD = 2;
  localparam int unsigned SEL_CMT = 3;

  logic        clk;
  logic        reset;
  logic        we;
  logic [1:0]  wd_type;
  logic [4:0]  waddr;
  logic [31:0] alu_res;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] wb_data;
  logic        wb_commit;

  typedef struct {
    int unsigned sel;
    int unsigned tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  grf_wb dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wd_type  (wd_type),
    .waddr    (waddr),
    .alu_res  (alu_res),
    .mem_data (mem_data),
    .pc       (pc),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_data  (wb_data),
    .wb_commit(wb_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sel_name(input int unsigned s);
    case (s)
      SEL_RD1: return "rdata1";
      SEL_RD2: return "rdata2";
      SEL_WBD: return "wb_data";
      default: return "wb_commit";
    endcase
  endfunction

  // Monitor: compare every pending expectation mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SEL_RD1: act = rdata1;
        SEL_RD2: act = rdata2;
        SEL_WBD: act = wb_data;
        default: act = {31'd0, wb_commit};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL chk%0d %s got %h expected %h", e.tag, sel_name(e.sel), act, e.val);
      end
    end
  end

  task automatic expect_val(input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag_n;
    e.val = val;
    tag_n++;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] t, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] p);
    we       = w;
    wd_type  = t;
    waddr    = a;
    alu_res  = alu;
    mem_data = mem;
    pc       = p;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    step();

    // Reset image
    raddr1 = 5'd28; raddr2 = 5'd29;
    expect_val(SEL_RD1, 32'h0000_1800);
    expect_val(SEL_RD2, 32'h0000_2ffc);
    expect_val(SEL_CMT, 32'd0);
    step();
    raddr1 = 5'd5;
    expect_val(SEL_RD1, 32'h0);
    // In reset: mux live, no commit, no bypass
    drive(1'b1, 2'd0, 5'd8, 32'h0000_0077, 32'h0, 32'h0);
    raddr2 = 5'd8;
    expect_val(SEL_WBD, 32'h0000_0077);
    expect_val(SEL_CMT, 32'd0);
    expect_val(SEL_RD2, 32'h0);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    raddr1 = 5'd8; raddr2 = 5'd8;
    expect_val(SEL_RD1, 32'h0);
    step();

    // ALU write with bypass on both ports
    drive(1'b1, 2'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0);
    raddr1 = 5'd8; raddr2 = 5'd8;
    expect_val(SEL_CMT, 32'd1);
    expect_val(SEL_RD1, 32'h1234_5678);
    expect_val(SEL_RD2, 32'h1234_5678);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    raddr2 = 5'd3;
    expect_val(SEL_RD1, 32'h1234_5678);
    expect_val(SEL_RD2, 32'h0);
    step();

    // Link writes, including wrap
    drive(1'b1, 2'd2, 5'd31, 32'h0, 32'h0, 32'h0000_3000);
    expect_val(SEL_WBD, 32'h0000_3008);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    raddr1 = 5'd31;
    expect_val(SEL_RD1, 32'h0000_3008);
    step();
    drive(1'b1, 2'd2, 5'd31, 32'h0, 32'h0, 32'hFFFF_FFFC);
    expect_val(SEL_WBD, 32'h0000_0004);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_val(SEL_RD1, 32'h0000_0004);
    step();

    // Memory path
    drive(1'b1, 2'd1, 5'd9, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0);
    expect_val(SEL_WBD, 32'hDEAD_BEEF);
    expect_val(SEL_CMT, 32'd1);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    raddr1 = 5'd9; raddr2 = 5'd8;
    expect_val(SEL_RD1, 32'hDEAD_BEEF);
    expect_val(SEL_RD2, 32'h1234_5678);
    step();

    // Write to $0 dropped
    drive(1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    raddr1 = 5'd0; raddr2 = 5'd0;
    expect_val(SEL_CMT, 32'd0);
    expect_val(SEL_RD1, 32'h0);
    expect_val(SEL_RD2, 32'h0);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_val(SEL_RD1, 32'h0);
    step();

    // Seed $10, then reserved type and we=0 must not change it
    drive(1'b1, 2'd0, 5'd10, 32'hCAFE_0010, 32'h0, 32'h0);
    step();
    drive(1'b1, 2'd3, 5'd10, 32'h1111_1111, 32'h2222_2222, 32'h0);
    raddr1 = 5'd10;
    expect_val(SEL_CMT, 32'd0);
    expect_val(SEL_WBD, 32'h0);
    expect_val(SEL_RD1, 32'hCAFE_0010);
    step();
    drive(1'b0, 2'd0, 5'd10, 32'h3333_3333, 32'h0, 32'h0);
    expect_val(SEL_CMT, 32'd0);
    expect_val(SEL_RD1, 32'hCAFE_0010);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_val(SEL_RD1, 32'hCAFE_0010);
    step();

    // Reset mid-operation
    drive(1'b1, 2'd0, 5'd8, 32'hA5A5_A5A5, 32'h0, 32'h0);
    step();
    drive(1'b1, 2'd0, 5'd8, 32'h0000_0001, 32'h0, 32'h0);
    raddr1 = 5'd8; raddr2 = 5'd10;
    #1;
    reset = 1'b0;
    expect_val(SEL_RD1, 32'h0);
    expect_val(SEL_RD2, 32'h0);
    expect_val(SEL_CMT, 32'd0);
    step();
    expect_val(SEL_RD1, 32'h0);
    step();
    expect_val(SEL_RD1, 32'h0);
    raddr2 = 5'd29;
    expect_val(SEL_RD2, 32'h0000_2ffc);
    step();
    reset = 1'b1;
    expect_val(SEL_CMT, 32'd1);
    expect_val(SEL_RD1, 32'h0000_0001);
    step();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_val(SEL_RD1, 32'h0000_0001);
    step();

    // Every queued expectation must have been consumed
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
